// File: rtl/table_fsm_pkg.sv
// Shared defaults, table entry layout and the power-up contents of the table_fsm transition table.
package table_fsm_pkg;

  localparam int SW_DEF = 3;
  localparam int IW_DEF = 2;
  localparam int OW_DEF = 3;

  // Entry layout: out in the low bits, next_state directly above it.
  localparam int OUT_LSB = 0;

  typedef enum logic {
    PH_INIT = 1'b0,
    PH_RUN  = 1'b1
  } phase_t;

  // Default entry: the state field of the address advances by one, and the output echoes that state field.
  function automatic logic [31:0] default_entry(input int unsigned addr,
                                                input int unsigned sw,
                                                input int unsigned ow);
    int unsigned st;
    int unsigned ns;
    int unsigned o;
    st = addr % (32'd1 << sw);
    ns = (st + 32'd1) % (32'd1 << sw);
    o  = st % (32'd1 << ow);
    return (ns << ow) | o;
  endfunction

endpackage

// File: rtl/table_fsm_mem.sv
// Transition table storage: one synchronous write port and one asynchronous read port.
// With TABLE_FSM_PARITY_EN defined, each entry also stores an even-parity bit, and reads check it.
module table_fsm_mem #(
  parameter int SW = 3,
  parameter int IW = 2,
  parameter int OW = 3
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [IW+SW-1:0]     waddr,
  input  logic [SW+OW-1:0]     wdata,
`ifdef TABLE_FSM_PARITY_EN
  input  logic                 par_flip,
`endif
  input  logic [IW+SW-1:0]     raddr,
  output logic [SW+OW-1:0]     rdata,
  output logic                 rd_ok
);

  localparam int DEPTH = 1 << (IW + SW);

  logic [SW+OW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

`ifdef TABLE_FSM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) par_mem[waddr] <= (^wdata) ^ par_flip;
  end

  assign rd_ok = ((^rdata) == par_mem[raddr]);
`else
  assign rd_ok = 1'b1;
`endif

endmodule

// File: rtl/table_fsm.sv
// Table-driven FSM: it self-initialises its transition table after reset, then steps on en and accepts writes on wr_en.
// Optional macro TABLE_FSM_PARITY_EN adds per-entry parity, the wr_par_flip input and a sticky err flag.
module table_fsm
  import table_fsm_pkg::*;
#(
  parameter int SW = SW_DEF,
  parameter int IW = IW_DEF,
  parameter int OW = OW_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [IW-1:0]        a,
  input  logic                 wr_en,
  input  logic [IW+SW-1:0]     wr_addr,
  input  logic [SW+OW-1:0]     wr_data,
`ifdef TABLE_FSM_PARITY_EN
  input  logic                 wr_par_flip,
`endif
  output logic [SW-1:0]        state,
  output logic [OW-1:0]        saida,
  output logic                 busy,
  output logic                 wr_ack,
  output logic                 err
);

  localparam int AW     = IW + SW;
  localparam int EW     = SW + OW;
  localparam int NS_LSB = OUT_LSB + OW;

  phase_t         phase;
  logic [AW-1:0]  init_addr;
  logic [31:0]    init_full;
  logic [EW-1:0]  init_data;
  logic           mem_we;
  logic [AW-1:0]  mem_waddr;
  logic [EW-1:0]  mem_wdata;
  logic [EW-1:0]  rd_data;
  logic           rd_ok;

  assign init_full = default_entry(32'(init_addr), SW, OW);
  assign init_data = init_full[EW-1:0];

  // During init the sequencer owns the write port, so user writes are ignored.
  assign mem_we    = busy | wr_en;
  assign mem_waddr = busy ? init_addr : wr_addr;
  assign mem_wdata = busy ? init_data : wr_data;

  table_fsm_mem #(.SW(SW), .IW(IW), .OW(OW)) u_mem (
    .clk      (clk),
    .we       (mem_we),
    .waddr    (mem_waddr),
    .wdata    (mem_wdata),
`ifdef TABLE_FSM_PARITY_EN
    .par_flip (wr_par_flip & ~busy),
`endif
    .raddr    ({a, state}),
    .rdata    (rd_data),
    .rd_ok    (rd_ok)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase     <= PH_INIT;
      busy      <= 1'b1;
      init_addr <= '0;
      state     <= '0;
      saida     <= '0;
      wr_ack    <= 1'b0;
`ifdef TABLE_FSM_PARITY_EN
      err       <= 1'b0;
`endif
    end else begin
      case (phase)
        PH_INIT: begin
          wr_ack <= 1'b0;
          if (&init_addr) begin
            phase     <= PH_RUN;
            busy      <= 1'b0;
            init_addr <= '0;
          end else begin
            init_addr <= init_addr + AW'(1);
          end
        end
        default: begin
          wr_ack <= wr_en;
          // The read is asynchronous, so a same-edge write to this entry only affects the next step.
          if (en) begin
            if (rd_ok) begin
              state <= rd_data[NS_LSB +: SW];
              saida <= rd_data[OUT_LSB +: OW];
            end
`ifdef TABLE_FSM_PARITY_EN
            else begin
              err <= 1'b1;
            end
`endif
          end
        end
      endcase
    end
  end

`ifndef TABLE_FSM_PARITY_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_table_fsm.sv
// Scoreboard bench for table_fsm: steps push expected {state,saida}, and a monitor compares after each accepted step.
module tb_table_fsm;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] a;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [5:0] wr_data;
`ifdef TABLE_FSM_PARITY_EN
  logic       wr_par_flip;
`endif
  logic [2:0] state;
  logic [2:0] saida;
  logic       busy;
  logic       wr_ack;
  logic       err;

  int checks   = 0;
  int failures = 0;

  logic [5:0] exp_q[$];
  logic       step_seen = 1'b0;
  int         cur_s = 0;
  int         cur_o = 0;

  table_fsm dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .a           (a),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
`ifdef TABLE_FSM_PARITY_EN
    .wr_par_flip (wr_par_flip),
`endif
    .state       (state),
    .saida       (saida),
    .busy        (busy),
    .wr_ack      (wr_ack),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  // Monitor: a step accepted at a rising edge is compared on the following falling edge.
  always @(posedge clk) step_seen = en && !busy && reset;

  always @(negedge clk) begin
    if (step_seen) begin
      logic [5:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL step_unexpected actual=%0d/%0d expected=none", state, saida);
      end else begin
        e = exp_q.pop_front();
        if (state !== e[5:3] || saida !== e[2:0]) begin
          failures++;
          $display("FAIL step actual=%0d/%0d expected=%0d/%0d", state, saida, e[5:3], e[2:0]);
        end
      end
    end
  end

  task automatic step(input int av, input int es, input int eo);
    @(negedge clk);
    a  = 2'(av);
    en = 1'b1;
    exp_q.push_back({3'(es), 3'(eo)});
    @(posedge clk);
    #1 en = 1'b0;
    cur_s = es;
    cur_o = eo;
  endtask

  // Walks the a=0 column, which must hold default entries along the path.
  task automatic goto_state(input int target);
    for (int i = 0; i < 8 && cur_s != target; i++)
      step(0, (cur_s + 1) % 8, cur_s);
  endtask

  task automatic wait_init(input string name);
    int cnt;
    int bad;
    cnt = 0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (state !== 3'd0 || saida !== 3'd0 || wr_ack !== 1'b0) bad++;
      if (!busy) break;
    end
    chk({name, "_busy_cycles"}, cnt, 32);
    chk({name, "_quiet_during_init"}, bad, 0);
    cur_s = 0;
    cur_o = 0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; a = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
`ifdef TABLE_FSM_PARITY_EN
    wr_par_flip = 1'b0;
`endif
    #12;
    chk("rst_state", state, 0);
    chk("rst_saida", saida, 0);
    chk("rst_busy", busy, 1);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_err", err, 0);

    // Init with en/wr_en asserted; both must be ignored.
    release_reset();
    en = 1'b1; wr_en = 1'b1; wr_addr = 5'd0; wr_data = 6'h3f;
    wait_init("init1");
    en = 1'b0; wr_en = 1'b0;

    // Default a=0 column walk with wrap.
    for (int i = 0; i < 8; i++) step(0, (i + 1) % 8, i);

    // Single write, then use it.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd18; wr_data = {3'd7, 3'd2};
    @(posedge clk);
    #1 wr_en = 1'b0;
    chk("wr_ack_pulse", wr_ack, 1);
    @(posedge clk);
    #1 chk("wr_ack_drop", wr_ack, 0);
    goto_state(2);
    step(2, 7, 2);

    // Back-to-back writes keep wr_ack high for two cycles.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd24; wr_data = {3'd3, 3'd5};
    @(posedge clk);
    #1 chk("b2b_ack1", wr_ack, 1);
    wr_addr = 5'd25; wr_data = {3'd6, 3'd1};
    @(posedge clk);
    #1 wr_en = 1'b0;
    chk("b2b_ack2", wr_ack, 1);
    @(posedge clk);
    #1 chk("b2b_ack_end", wr_ack, 0);
    step(0, 0, 7);
    step(3, 3, 5);

    // Same-edge step and write to entry 1: step sees the old entry.
    goto_state(1);
    @(negedge clk);
    a = 2'd0; en = 1'b1; wr_en = 1'b1; wr_addr = 5'd1; wr_data = {3'd5, 3'd4};
    exp_q.push_back({3'd2, 3'd1});
    @(posedge clk);
    #1 en = 1'b0; wr_en = 1'b0;
    cur_s = 2; cur_o = 1;
    goto_state(1);
    step(0, 5, 4);

    // Asynchronous reset mid-operation, then reset again mid-init.
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_saida", saida, 0);
    chk("async_rst_busy", busy, 1);
    release_reset();
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("midinit_rst_busy", busy, 1);
    release_reset();
    wait_init("init2");

    // User-programmed entries revert to defaults after init.
    goto_state(1);
    step(0, 2, 1);
    step(2, 3, 2);

`ifdef TABLE_FSM_PARITY_EN
    @(negedge clk);
    wr_en = 1'b1; wr_par_flip = 1'b1; wr_addr = 5'd0; wr_data = {3'd1, 3'd0};
    @(posedge clk);
    #1 wr_en = 1'b0; wr_par_flip = 1'b0;
    goto_state(0);
    @(negedge clk);
    a = 2'd0; en = 1'b1;
    exp_q.push_back({3'd0, 3'(cur_o)});
    @(posedge clk);
    #1 en = 1'b0;
    chk("par_err_set", err, 1);
    chk("par_state_hold", state, 0);
    repeat (3) @(posedge clk);
    #1 chk("par_err_sticky", err, 1);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("par_err_cleared", err, 0);
    release_reset();
    wait_init("init3");
`else
    chk("err_tied_low", err, 0);
`endif

    repeat (2) @(posedge clk);
    #1 chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/table_fsm.md
TABLE_FSM -- requirements
Module: table_fsm

Interface
REQ-001 Parameter SW, default 3, state width in bits (2^SW states).
REQ-002 Parameter IW, default 2, input symbol width in bits.
REQ-003 Parameter OW, default 3, output width in bits.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  step request; advances the FSM by one transition.
REQ-007 a  input  IW  input symbol sampled on a step.
REQ-008 wr_en  input  1  table write request.
REQ-009 wr_addr  input  IW+SW  table entry address, {a, state} ordering.
REQ-010 wr_data  input  SW+OW  entry contents, {next_state, out}.
REQ-011 state  output  SW  current state register.
REQ-012 saida  output  OW  registered output of the last transition.
REQ-013 busy  output  1  high while the table self-initialises.
REQ-014 wr_ack  output  1  one-cycle pulse confirming an accepted write.
REQ-015 err  output  1  sticky table parity error flag.

Function
REQ-016 Transition table SHALL hold 2^(IW+SW) entries; entry address = {a, state}, a in the upper bits.
REQ-017 Entry fields SHALL be next_state in the upper SW bits and out in the lower OW bits.
REQ-018 On the first rising edge after reset release, init SHALL begin; busy=1; one entry is written per cycle at addresses 0 .. 2^(IW+SW)-1 ascending.
REQ-019 Default entry SHALL be next_state = (addr[SW-1:0]+1) mod 2^SW and out = addr[SW-1:0] zero-extended or truncated to OW.
REQ-020 busy SHALL fall on the edge that writes the last entry: exactly 2^(IW+SW) cycles high (32 cycles at default parameters).
REQ-021 While busy=1, en and wr_en SHALL be ignored and wr_ack SHALL stay 0.
REQ-022 Step: with busy=0 and en=1 at an edge, state <= entry[{a,state}].next_state and saida <= entry[{a,state}].out; latency 1 cycle.
REQ-023 With en=0, state and saida SHALL hold.
REQ-024 Write: with busy=0 and wr_en=1 at an edge, the entry at wr_addr SHALL take wr_data; wr_ack SHALL be 1 for the following cycle only.
REQ-025 Back-to-back writes SHALL be accepted every cycle; wr_ack SHALL stay high for as many cycles as writes were accepted.
REQ-026 A simultaneous step and write to the same entry SHALL use the old contents for the step (read-before-write); the new contents apply from the next step.
REQ-027 State wrap SHALL be modulo 2^SW with no saturation; every state is legal.

Reset
REQ-028 Reset assertion SHALL immediately force state=0, saida=0, wr_ack=0, err=0 and busy=1.
REQ-029 Reset mid-init or mid-operation SHALL discard progress; init SHALL restart at address 0 after release, overwriting all user-programmed entries.

Configuration
REQ-030 Macro TABLE_FSM_PARITY_EN defined: each entry SHALL store an extra even-parity bit over {next_state,out}, and an extra input wr_par_flip (1 bit) SHALL invert the stored parity bit on a write.
REQ-031 With the macro defined, a step that reads an entry with a parity mismatch SHALL set err (sticky until reset) and SHALL hold state and saida unchanged.
REQ-032 Macro absent: no parity storage, no wr_par_flip port, err tied to 0.

Structure
REQ-033 Package table_fsm_pkg SHALL hold the parameter defaults, the entry field offsets and the default-entry function.
REQ-034 Storage SHALL be the sub-module table_fsm_mem: one write port, one asynchronous read port, and parity generation and check under the macro.

Verification
REQ-035 Reset, then count cycles -> busy high for exactly 32 cycles; state=0, saida=0 throughout.
REQ-036 After init, a=0, en=1 for 8 cycles -> state sequence 1,2,...,7,0; saida 0,1,...,7.
REQ-037 Write addr 18 (a=2, state=2) data {7,2}; drive state to 2, a=2, step -> state=7, saida=2; wr_ack pulsed once.
REQ-038 Same-edge write addr 1 data {5,4} with step from state 1, a=0 -> state=2 (old entry); step again from state 1 -> state=5.
REQ-039 Assert reset at init cycle 10, release -> busy 32 more cycles; a previously written entry reverts to its default.
REQ-040 With TABLE_FSM_PARITY_EN: write addr 0 with wr_par_flip=1, step from state 0, a=0 -> err=1 and state stays 0; err clears only on reset.
